// File: rtl/norm_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : norm_pkg
//  Description : Shared types and helpers for the bishift_normalize_8 block:
//                FSM state encoding, default data width, bit-reverse helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package norm_pkg;

    localparam int NORM_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } norm_state_t;

    // Reverse the low n bits of v; bits above n come back as zero.
    // Reversing the full 64-bit container puts the n data bits at the top,
    // reversed, so shifting back down by (64-n) leaves them right-aligned.
    function automatic logic [63:0] bit_reverse(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = {<<{v}};
        return r >> (64 - n);
    endfunction

endpackage : norm_pkg
`default_nettype wire

// File: rtl/bishift_normalize_8_stage.sv
`default_nettype none
// ============================================================================
//  Module      : norm_stage
//  Description : One combinational normalization stage. If the top 2^k bits
//                of the word are all zero, shift the word left by 2^k
//                (zero fill) and report amount bit = 1; otherwise pass the
//                word through and report 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module norm_stage
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int KW    = 2
) (
    input  logic [WIDTH-1:0] i_w,
    input  logic [KW-1:0]    i_k,
    output logic [WIDTH-1:0] o_w,
    output logic             o_bit
);

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_shifted;

    // Mask selecting the top 2^k bits of the word.
    assign w_mask    = ~({WIDTH{1'b1}} >> (32'd1 << i_k));
    assign w_shifted = i_w << (32'd1 << i_k);

    assign o_bit = ((i_w & w_mask) == '0);
    assign o_w   = o_bit ? w_shifted : i_w;

endmodule : norm_stage
`default_nettype wire

// File: rtl/bishift_normalize_8.sv
`default_nettype none
// ============================================================================
//  Module      : bishift_normalize_8
//  Description : Sequential left/right normalizer with valid/ready handshakes.
//                Finds the leading-zero (left) or trailing-zero (right) count
//                of a word and returns the normalized word plus the count.
//                Right normalization is done by bit-reversing into and out of
//                a left-normalizing datapath.
//  Config      : NORM_SINGLE_CYCLE_EN - when defined, all stages are resolved
//                combinationally in one STEP cycle; otherwise one stage per
//                cycle through a single shared stage instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module bishift_normalize_8
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           data,
    input  logic                       left,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           norm_out,
    output logic [$clog2(WIDTH)-1:0]   amount,
    output logic                       zero
);

    localparam int STAGES = $clog2(WIDTH);

    norm_state_t       r_state;
    norm_state_t       w_state_nxt;
    logic [WIDTH-1:0]  r_w;
    logic [STAGES-1:0] r_amt;
    logic              r_left;

    logic [WIDTH-1:0]  w_data_rev;
    logic [WIDTH-1:0]  w_work_rev;
    logic              w_last_step;

    assign w_data_rev = WIDTH'(bit_reverse(64'(data), WIDTH));
    assign w_work_rev = WIDTH'(bit_reverse(64'(r_w),  WIDTH));

`ifdef NORM_SINGLE_CYCLE_EN
    // ---------------- all stages chained in one cycle ----------------
    localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic [WIDTH-1:0]  w_chain [STAGES+1];
    logic [STAGES-1:0] w_chain_bits;

    assign w_chain[STAGES] = r_w;
    assign w_last_step     = 1'b1;

    // Widest stage first so each later stage sees the already-shifted word.
    for (genvar j = 0; j < STAGES; j++) begin : g_chain
        norm_stage #(
            .WIDTH (WIDTH),
            .KW    (KW)
        ) u_stage (
            .i_w   (w_chain[j+1]),
            .i_k   (KW'(j)),
            .o_w   (w_chain[j]),
            .o_bit (w_chain_bits[j])
        );
    end
`else
    // ---------------- one shared stage, stepped by r_k ----------------
    localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic [KW-1:0]     r_k;
    logic [WIDTH-1:0]  w_stage_w;
    logic              w_stage_bit;

    assign w_last_step = (r_k == '0);

    norm_stage #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_stage (
        .i_w   (r_w),
        .i_k   (r_k),
        .o_w   (w_stage_w),
        .o_bit (w_stage_bit)
    );
`endif

    // State register; reset forces IDLE and discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)    w_state_nxt = ST_STEP;
            ST_STEP: if (w_last_step) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)   w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Working word, amount and direction: loaded on accept, refined per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w    <= '0;
            r_amt  <= '0;
            r_left <= 1'b0;
`ifndef NORM_SINGLE_CYCLE_EN
            r_k    <= KW'(STAGES - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_left <= left;
                        r_w    <= left ? data : w_data_rev;
                        r_amt  <= '0;
`ifndef NORM_SINGLE_CYCLE_EN
                        r_k    <= KW'(STAGES - 1);
`endif
                    end
                end
                ST_STEP: begin
`ifdef NORM_SINGLE_CYCLE_EN
                    r_w   <= w_chain[0];
                    r_amt <= w_chain_bits;
`else
                    r_w        <= w_stage_w;
                    r_amt[r_k] <= w_stage_bit;
                    r_k        <= r_k - 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Outputs: results are only presented in DONE, zero elsewhere.
    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !rst;
        out_valid = (r_state == ST_DONE);
        norm_out  = '0;
        amount    = '0;
        zero      = 1'b0;
        if (r_state == ST_DONE) begin
            norm_out = r_left ? r_w : w_work_rev;
            amount   = r_amt;
            zero     = (r_w == '0);
        end
    end

endmodule : bishift_normalize_8
`default_nettype wire
